// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_e;

  typedef logic master_id_t;

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wr_data;
  } cmd_t;

  // A request with both strobes set is treated as a write.
  function automatic cmd_t make_cmd(input logic wr, input logic rd,
                                    input logic [ADDR_W_DEF-1:0] addr,
                                    input logic [DATA_W_DEF-1:0] wr_data);
    cmd_t c;
    c.wr      = wr;
    c.rd      = rd & ~wr;
    c.addr    = addr;
    c.wr_data = wr_data;
    return c;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// FPro MMIO bus bundle: the arbiter drives it as master, the MMIO controller is the slave.
interface mmio_bus_arbiter_if import mmio_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cs;
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (output cs, output wr, output rd, output addr, output wr_data,
                  input rd_data);
  modport slave  (input cs, input wr, input rd, input addr, input wr_data,
                  output rd_data);
endinterface

// File: rtl/mmio_arb_picker.sv
// Combinational winner selection for the MMIO arbiter.
// MMIO_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise master 0 wins ties.
module mmio_arb_picker import mmio_arb_pkg::*; (
  input  logic       req0,
  input  logic       req1,
`ifdef MMIO_ARB_ROUND_ROBIN_EN
  input  master_id_t last_grant,
`endif
  input  logic       lock,
  output logic       grant_valid,
  output master_id_t grant_id
);

  // Lock only holds master 1 off while master 0 is still asking
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = 1'b0;
    if (lock && req0) begin
      grant_id = 1'b0;
    end else if (req0 && req1) begin
`ifdef MMIO_ARB_ROUND_ROBIN_EN
      grant_id = ~last_grant;
`else
      grant_id = 1'b0;
`endif
    end else if (req1) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter serialising accesses onto the FPro MMIO bus (IDLE -> ISSUE -> ACK).
// Optional MMIO_ARB_ROUND_ROBIN_EN enables round-robin tie-break (default: fixed priority).
module mmio_bus_arbiter import mmio_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_rd,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_rd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_ack,
  mmio_bus_arbiter_if.master mmio,
  output logic              busy
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              grant_valid_s;
  master_id_t        grant_id_s;
  master_id_t        id_r;
  logic              lock_r;
  cmd_t              cmd_r;
  cmd_t              sel_cmd_s;
  logic              cs_r;
  logic              m0_ack_r;
  logic              m1_ack_r;
  logic [DATA_W-1:0] m0_rd_data_r;
  logic [DATA_W-1:0] m1_rd_data_r;
  logic              busy_r;

`ifdef MMIO_ARB_ROUND_ROBIN_EN
  master_id_t last_grant_r;

  // Most recent winner, consulted only when both masters request
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && grant_valid_s) begin
      last_grant_r <= grant_id_s;
    end
  end
`endif

  mmio_arb_picker u_picker (
    .req0        (m0_req),
    .req1        (m1_req),
`ifdef MMIO_ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_r),
`endif
    .lock        (lock_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Command of the current winner, ready to be latched
  always_comb begin
    sel_cmd_s = make_cmd(m0_wr, m0_rd, m0_addr, m0_wr_data);
    if (grant_id_s == 1'b1) begin
      sel_cmd_s = make_cmd(m1_wr, m1_rd, m1_addr, m1_wr_data);
    end else begin
      sel_cmd_s = make_cmd(m0_wr, m0_rd, m0_addr, m0_wr_data);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Command latch, one-cycle bus strobes, acknowledge pulse and read capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_r        <= '0;
      id_r         <= 1'b0;
      cs_r         <= 1'b0;
      lock_r       <= 1'b0;
      m0_ack_r     <= 1'b0;
      m1_ack_r     <= 1'b0;
      m0_rd_data_r <= '0;
      m1_rd_data_r <= '0;
      busy_r       <= 1'b0;
    end else begin
      cs_r     <= 1'b0;
      cmd_r.wr <= 1'b0;
      cmd_r.rd <= 1'b0;
      m0_ack_r <= 1'b0;
      m1_ack_r <= 1'b0;
      busy_r   <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            cmd_r  <= sel_cmd_s;
            id_r   <= grant_id_s;
            cs_r   <= 1'b1;
            lock_r <= (grant_id_s == 1'b0) && m0_lock;
          end else begin
            lock_r <= 1'b0;
          end
        end
        ISSUE: begin
          m0_ack_r <= (id_r == 1'b0);
          m1_ack_r <= (id_r == 1'b1);
          if (cmd_r.rd) begin
            if (id_r == 1'b1) begin
              m1_rd_data_r <= mmio.rd_data;
            end else begin
              m0_rd_data_r <= mmio.rd_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mmio.cs      = cs_r;
  assign mmio.wr      = cmd_r.wr;
  assign mmio.rd      = cmd_r.rd;
  assign mmio.addr    = cmd_r.addr;
  assign mmio.wr_data = cmd_r.wr_data;
  assign m0_ack       = m0_ack_r;
  assign m1_ack       = m1_ack_r;
  assign m0_rd_data   = m0_rd_data_r;
  assign m1_rd_data   = m1_rd_data_r;
  assign busy         = busy_r;

endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Two-master arbiter that shares the single FPro MMIO bus (cs/wr/rd, 21-bit address, 32-bit data) between the processor bridge (master 0) and a secondary bus master (master 1, e.g. a MIDI/SSEG sequencing engine). It sits between the masters and the MMIO controller, serialises their accesses into single-cycle bus transactions and returns read data with a one-cycle acknowledge.

## Interface

Parameters:
- ADDR_W, 21, MMIO address width (11 LSBs decoded downstream)
- DATA_W, 32, MMIO data width

Ports (single clock; reset is synchronous and active-low):
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- m0_req  in  1  master 0 request, level
- m0_wr  in  1  master 0 write strobe qualifier
- m0_rd  in  1  master 0 read strobe qualifier
- m0_lock  in  1  master 0 keeps ownership after its transaction
- m0_addr  in  ADDR_W  master 0 address
- m0_wr_data  in  DATA_W  master 0 write data
- m0_rd_data  out  DATA_W  master 0 read data, valid with m0_ack
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse
- m1_req, m1_wr, m1_rd, m1_addr, m1_wr_data, m1_rd_data, m1_ack: same as master 0 (no lock)
- mmio_cs  out  1  bus chip select
- mmio_wr  out  1  bus write
- mmio_rd  out  1  bus read
- mmio_addr  out  ADDR_W  bus address
- mmio_wr_data  out  DATA_W  bus write data
- mmio_rd_data  in  DATA_W  bus read data, combinational from slot
- busy  out  1  high whenever state is not IDLE

## Operation

- FSM states: IDLE, ISSUE, ACK.
- IDLE: if any req high, pick winner, latch its wr/rd/addr/wr_data and id into command registers, go to ISSUE. No req: stay.
- ISSUE: drive mmio_cs=1 and the latched mmio_wr/mmio_rd/addr/data for exactly one cycle; capture mmio_rd_data into the read register when latched rd=1; go to ACK.
- ACK: pulse winner's ack; winner's rd_data holds the captured word (stays until the next read for that master); go to IDLE.
- Requester holds req and command stable until it samples ack; req still high in the cycle after ack counts as a new request.
- wr and rd both high: write wins, rd ignored. req with neither set: bus cycle issued with mmio_cs=1, wr=rd=0, still acked.
- Arbitration: both requesting → grant the master not granted last (last_grant reg, reset value 1 so master 0 wins first tie). Single requester always granted.
- Lock: if previous winner was master 0 with m0_lock=1 latched, master 1 is not granted until a master 0 transaction completes with m0_lock=0 or m0_req drops in IDLE.
- Reset (any state, any cycle): return to IDLE, abandon the transaction without ack, clear lock, last_grant=1.

## Timing

- Reset values: mmio_cs/wr/rd=0, mmio_addr=0, mmio_wr_data=0, m0/m1_ack=0, m0/m1_rd_data=0, busy=0.
- Latency: req sampled in IDLE at edge N → mmio_cs high cycle N+1 → ack high cycle N+2. Minimum 3-cycle period per transaction; back-to-back alternating masters sustain one transaction per 3 cycles.
- Bus outputs are registered; mmio_cs is low in IDLE and ACK.
- Only one ack high in any cycle; never both.

## Configuration

- MMIO_ARB_ROUND_ROBIN_EN defined: round-robin tie-break as above.
- Not defined: fixed priority, master 0 always wins ties; last_grant register removed; lock behaviour unchanged.

## Structure

- Package mmio_arb_pkg: state enum (IDLE, ISSUE, ACK), master-id typedef (1 bit), ADDR_W/DATA_W default constants, command struct (wr, rd, addr, wr_data).
- Sub-module mmio_arb_picker: combinational winner selection from req, last_grant, lock, returning grant valid and id; round-robin/fixed compile switch lives there.

## Test plan

- m0 write addr 0x00010, data 0x0000_00A5 alone → mmio_cs/mmio_wr high exactly one cycle with those values, m0_ack two cycles after req sampled, m1_ack never high.
- m1 read addr 0x00060 with slot returning 0xDEAD_BEEF → mmio_rd one cycle, m1_rd_data=0xDEAD_BEEF with m1_ack.
- Both req held high for 6 transactions after reset (RR enabled) → grant order m0,m1,m0,m1,m0,m1; fixed-priority build → six m0 grants.
- m0 three transactions with m0_lock=1 then one with lock=0, m1 requesting throughout → m1 granted only after the fourth m0 ack.
- reset=0 during ISSUE → next cycle all outputs at reset values, no ack pulse; after release, held request re-issued cleanly.
- m0 req with wr=rd=1, addr 0x00020 → mmio_wr=1, mmio_rd=0, m0_rd_data unchanged.
